// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues word addresses to a fixed-latency read port,
// tracks requests in flight, and buffers pc-tagged instructions for decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MEM_LAT  = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [15:0]                  flush_target,
    input  logic                         halt,
    output logic [14:0]                  imem_raddr,
    input  logic [15:0]                  imem_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_instr,
    output logic [15:0]                  out_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(DEPTH + MEM_LAT + 1);

    logic [15:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic          pipe_valid_q [MEM_LAT];
    logic          pipe_valid_d [MEM_LAT];
    logic [15:0]   pipe_pc_q    [MEM_LAT];
    logic [15:0]   pipe_pc_d    [MEM_LAT];

    logic [15:0]   fifo_instr_q [DEPTH];
    logic [15:0]   fifo_instr_d [DEPTH];
    logic [15:0]   fifo_pc_q    [DEPTH];
    logic [15:0]   fifo_pc_d    [DEPTH];

    logic [SW-1:0] inflight;
    logic [SW-1:0] occupancy;
    logic          issue;
    logic          push;
    logic          pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + SW'(pipe_valid_q[i]);
        end
    end

    // Credit uses the registered count, so a pop only frees a slot from the next cycle.
    assign occupancy = SW'(count_q) + inflight;
    assign issue     = !flush && !halt && (occupancy < SW'(DEPTH));
    assign push      = pipe_valid_q[MEM_LAT-1] && !flush;
    assign pop       = (count_q != '0) && out_ready && !flush;

    assign pipe_valid_d[0] = issue;
    assign pipe_pc_d[0]    = pc_q;

    generate
        for (genvar gi = 1; gi < MEM_LAT; gi++) begin : g_pipe
            assign pipe_valid_d[gi] = pipe_valid_q[gi-1] && !flush;
            assign pipe_pc_d[gi]    = pipe_pc_q[gi-1];
        end
    endgenerate

    always_comb begin
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        if (push) begin
            fifo_instr_d[wr_ptr_q] = imem_rdata;
            fifo_pc_d[wr_ptr_q]    = pipe_pc_q[MEM_LAT-1];
        end
    end

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            pc_d     = flush_target & 16'hFFFE;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (issue) begin
                pc_d = pc_q + 16'd2;
            end
            count_d  = count_q + CW'(push) - CW'(pop);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
        end
    end

    always_ff @(posedge clk) begin
        pipe_pc_q    <= pipe_pc_d;
        fifo_instr_q <= fifo_instr_d;
        fifo_pc_q    <= fifo_pc_d;
        if (rst) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_valid_q[i] <= 1'b0;
            end
        end else begin
            pc_q         <= pc_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            pipe_valid_q <= pipe_valid_d;
        end
    end

    assign imem_raddr = pc_q[15:1];
    assign out_valid  = (count_q != '0);
    assign out_instr  = fifo_instr_q[rd_ptr_q];
    assign out_pc     = fifo_pc_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue-level model checked every cycle,
// plus hand-computed expectations at key cycles of each scenario.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          MEM_LAT  = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          CW       = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [15:0]   flush_target = 16'h0000;
    logic          halt = 1'b0;
    logic          out_ready = 1'b0;
    logic [14:0]   imem_raddr;
    logic [15:0]   imem_rdata;
    logic          out_valid;
    logic [15:0]   out_instr;
    logic [15:0]   out_pc;
    logic [CW-1:0] count;

    int n_vec  = 0;
    int n_fail = 0;
    int dc     = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_target(flush_target), .halt(halt),
        .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .count(count)
    );

    function automatic logic [15:0] word_instr(input logic [14:0] w);
        return 16'h1000 + {1'b0, w};
    endfunction

    // Memory: word k holds 16'h1000+k, returned MEM_LAT cycles after its address.
    logic [15:0] mem_pipe [MEM_LAT];
    always @(posedge clk) begin
        mem_pipe[0] <= word_instr(imem_raddr);
        for (int i = 1; i < MEM_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign imem_rdata = mem_pipe[MEM_LAT-1];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: requests in flight and queued entries tracked as pc lists.
    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] cyc;
    } flight_t;

    flight_t     inf_q [$];
    logic [15:0] q_pc  [$];
    logic [15:0] m_pc = 16'h0000;
    logic [31:0] m_cyc = 0;
    bit          m_init = 1'b0;

    initial begin
        bit do_issue, do_pop, do_land;
        forever begin
            @(posedge clk);
            if (rst) begin
                inf_q.delete();
                q_pc.delete();
                m_pc   = RESET_PC;
                m_init = 1'b1;
            end else if (flush) begin
                inf_q.delete();
                q_pc.delete();
                m_pc = flush_target & 16'hFFFE;
            end else begin
                do_issue = !halt && (q_pc.size() + inf_q.size() < DEPTH);
                do_pop   = (q_pc.size() != 0) && out_ready;
                do_land  = (inf_q.size() != 0) && (inf_q[0].cyc + MEM_LAT == m_cyc);
                if (do_pop) void'(q_pc.pop_front());
                if (do_land) begin
                    q_pc.push_back(inf_q[0].pc);
                    void'(inf_q.pop_front());
                end
                if (do_issue) begin
                    inf_q.push_back('{pc: m_pc, cyc: m_cyc});
                    m_pc = m_pc + 16'd2;
                end
            end
            m_cyc = m_cyc + 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_init) begin
                check("model_valid", 16'(out_valid), 16'(q_pc.size() != 0));
                check("model_count", 16'(count), 16'(q_pc.size()));
                if (q_pc.size() != 0) begin
                    check("model_pc", out_pc, q_pc[0]);
                    check("model_instr", out_instr, word_instr(q_pc[0][15:1]));
                end
                if (!rst && !flush && !halt && (q_pc.size() + inf_q.size() < DEPTH))
                    check("model_raddr", 16'(imem_raddr), 16'(m_pc[15:1]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int k);
        while (dc < k) begin
            tick();
            dc++;
        end
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        halt = 1'b0;
        tick();
        nedge();
        check("rst_count", 16'(count), 16'h0000);
        check("rst_valid", 16'(out_valid), 16'h0000);
        tick();
        rst = 1'b0;
        dc = 0;
    endtask

    logic [23:0] rdy_pat  = 24'b1011_0010_1110_0111_0001_1101;
    logic [23:0] halt_pat = 24'b0000_1100_0000_0110_0000_0000;

    initial begin
        // Streaming from reset
        do_reset();
        out_ready = 1'b1;
        nedge(); check("s1_raddr0", 16'(imem_raddr), 16'h0000);
                 check("s1_valid0", 16'(out_valid), 16'h0000);
        go(2); nedge(); check("s1_valid2", 16'(out_valid), 16'h0000);
        go(3); nedge(); check("s1_valid3", 16'(out_valid), 16'h0001);
                        check("s1_pc3", out_pc, 16'h0000);
                        check("s1_instr3", out_instr, 16'h1000);
        go(4); nedge(); check("s1_pc4", out_pc, 16'h0002);
                        check("s1_instr4", out_instr, 16'h1001);
        go(5); nedge(); check("s1_pc5", out_pc, 16'h0004);
                        check("s1_count5", 16'(count), 16'h0001);

        // Back-pressure saturates the queue
        go(6); out_ready = 1'b0;
        go(15); nedge(); check("s2_count_sat", 16'(count), 16'h0004);
                         check("s2_pc_hold", out_pc, 16'h0006);
        go(16); out_ready = 1'b1;
        go(17); nedge(); check("s2_pc_resume", out_pc, 16'h0008);
        go(24);

        // Flush with two requests in flight
        do_reset();
        out_ready = 1'b1;
        go(6); flush = 1'b1; flush_target = 16'h0040;
        go(7); flush = 1'b0;
        nedge(); check("s3_count7", 16'(count), 16'h0000);
                 check("s3_valid7", 16'(out_valid), 16'h0000);
                 check("s3_raddr7", 16'(imem_raddr), 16'h0020);
        go(8);  nedge(); check("s3_valid8", 16'(out_valid), 16'h0000);
        go(9);  nedge(); check("s3_valid9", 16'(out_valid), 16'h0000);
        go(10); nedge(); check("s3_pc10", out_pc, 16'h0040);
                         check("s3_instr10", out_instr, 16'h1020);

        // Flush coinciding with a pop and an arriving response; odd target
        go(14); flush = 1'b1; flush_target = 16'h0101;
        go(15); flush = 1'b0;
        nedge(); check("s4_count", 16'(count), 16'h0000);
        go(18); nedge(); check("s4_pc", out_pc, 16'h0100);
                         check("s4_instr", out_instr, 16'h1080);

        // pc wrap
        go(22); flush = 1'b1; flush_target = 16'hFFFC;
        go(23); flush = 1'b0;
        nedge(); check("s5_raddr", 16'(imem_raddr), 16'h7FFE);
        go(26); nedge(); check("s5_pc0", out_pc, 16'hFFFC);
                         check("s5_instr0", out_instr, 16'h8FFE);
        go(27); nedge(); check("s5_pc1", out_pc, 16'hFFFE);
                         check("s5_instr1", out_instr, 16'h8FFF);
        go(28); nedge(); check("s5_pc2", out_pc, 16'h0000);
                         check("s5_instr2", out_instr, 16'h1000);
        go(29); nedge(); check("s5_pc3", out_pc, 16'h0002);

        // Halt mid-stream for five cycles
        go(32); halt = 1'b1;
        go(36); nedge(); check("s6_valid_drained", 16'(out_valid), 16'h0000);
                         check("s6_count_drained", 16'(count), 16'h0000);
        go(37); halt = 1'b0;
        nedge(); check("s6_raddr_resume", 16'(imem_raddr), 16'h0007);
        go(40); nedge(); check("s6_pc_resume", out_pc, 16'h000E);

        // Flush while halted
        go(42); halt = 1'b1;
        go(43); flush = 1'b1; flush_target = 16'h0300;
        go(44); flush = 1'b0;
        go(45); halt = 1'b0;
        nedge(); check("s6b_raddr", 16'(imem_raddr), 16'h0180);
        go(48); nedge(); check("s6b_pc", out_pc, 16'h0300);
                         check("s6b_instr", out_instr, 16'h1180);

        // Reset pulsed mid-stream
        go(55); rst = 1'b1;
        go(56); rst = 1'b0;
        nedge(); check("s7_count", 16'(count), 16'h0000);
                 check("s7_valid", 16'(out_valid), 16'h0000);
                 check("s7_raddr", 16'(imem_raddr), 16'h0000);
        go(59); nedge(); check("s7_valid_first", 16'(out_valid), 16'h0001);
                         check("s7_pc_first", out_pc, RESET_PC);
                         check("s7_instr_first", out_instr, 16'h1000);

        // Mixed ready/halt pattern, checked by the model alone
        for (int i = 0; i < 24; i++) begin
            go(60 + i);
            out_ready = rdy_pat[i];
            halt      = halt_pat[i];
        end
        go(84); out_ready = 1'b1; halt = 1'b0;
        go(96);
        nedge();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
